// File: rtl/dm_access_pkg.sv
// Shared encodings and decode helpers for the dm_4k load/store controller.
package dm_access_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADEL = 2'd1;
  localparam logic [1:0] ERR_ADES = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_byte(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic [3:0] be_decode(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] be;
    if (is_byte(op)) begin
      be = 4'b0001 << lo;
    end else if (is_half(op)) begin
      be = lo[1] ? 4'b1100 : 4'b0011;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// CPU-side request/response bus of the load/store controller.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] resp_badaddr;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane of a dm_4k read word and sign/zero-extends it.
module lsu_load_align
  import dm_access_pkg::*;
(
  input  logic [31:0] dout_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = dout_i[7:0];
      2'd1:    byte_s = dout_i[15:8];
      2'd2:    byte_s = dout_i[23:16];
      2'd3:    byte_s = dout_i[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = addr_lo_i[1] ? dout_i[31:16] : dout_i[15:0];
    case (op_i)
      OP_LW:   data_o = dout_i;
      OP_LH:   data_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  data_o = {16'd0, half_s};
      OP_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data_o = {24'd0, byte_s};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller in front of dm_4k: alignment/window checks, byte
// enables, load extraction and a held response with MIPS address-error codes.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DM_BYTES  = 4096
)
(
  input  logic        clk,
  input  logic        rst,
  dm_access_ctrl_if.slave cpu_if,
  output logic [9:0]  dm_addr_o,
  output logic [31:0] dm_din_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  input  logic [31:0] dm_dout_i
);

  localparam logic [31:0] DM_WINDOW = 32'(DM_BYTES);

  state_t      state_q;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic [9:0]  word_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;
  logic [31:0] badaddr_q;

  logic [31:0] offset_s;
  logic        misalign_s;
  logic        fault_s;
  logic [31:0] load_data_s;

  // Wrapping offset makes addresses below BASE_ADDR land out of window
  always_comb begin
    offset_s = cpu_if.req_addr - BASE_ADDR;
    if (is_byte(cpu_if.req_op)) begin
      misalign_s = 1'b0;
    end else if (is_half(cpu_if.req_op)) begin
      misalign_s = cpu_if.req_addr[0];
    end else begin
      misalign_s = |cpu_if.req_addr[1:0];
    end
    fault_s = misalign_s || (offset_s >= DM_WINDOW);
  end

  lsu_load_align u_align (
    .dout_i    (dm_dout_i),
    .op_i      (op_q),
    .addr_lo_i (lo_q),
    .data_o    (load_data_s)
  );

  assign dm_addr_o = word_q;
  assign dm_din_o  = wdata_q;
  assign dm_we_o   = (state_q == S_ACCESS) && is_store(op_q);
  assign dm_be_o   = (state_q == S_ACCESS) ? be_decode(op_q, lo_q) : 4'b0000;

  assign cpu_if.req_ready    = req_ready_q;
  assign cpu_if.resp_valid   = resp_valid_q;
  assign cpu_if.resp_rdata   = rdata_q;
  assign cpu_if.resp_err     = err_q;
  assign cpu_if.resp_badaddr = badaddr_q;

  // Transaction FSM with capture and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      lo_q         <= 2'd0;
      word_q       <= 10'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= ERR_NONE;
      badaddr_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_if.req_valid) begin
            op_q        <= cpu_if.req_op;
            lo_q        <= cpu_if.req_addr[1:0];
            word_q      <= offset_s[11:2];
            wdata_q     <= cpu_if.req_wdata;
            req_ready_q <= 1'b0;
            if (fault_s) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= 32'd0;
              err_q        <= is_store(cpu_if.req_op) ? ERR_ADES : ERR_ADEL;
              badaddr_q    <= cpu_if.req_addr;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          rdata_q      <= is_store(op_q) ? 32'd0 : load_data_s;
          err_q        <= ERR_NONE;
          badaddr_q    <= 32'd0;
        end
        S_RESP: begin
          if (cpu_if.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: byte-level reference model, dm_4k stand-ins,
// and a per-cycle response comparator.
`timescale 1ns/1ps
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  dm_access_ctrl_if bus();
  dm_access_ctrl_if bus2();

  logic [9:0]  dm_addr, dm2_addr;
  logic [31:0] dm_din, dm2_din, dm_dout, dm2_dout;
  logic        dm_we, dm2_we;
  logic [3:0]  dm_be, dm2_be;

  dm_access_ctrl #(.BASE_ADDR(32'h0000_0000), .DM_BYTES(4096)) u_dut (
    .clk(clk), .rst(rst), .cpu_if(bus),
    .dm_addr_o(dm_addr), .dm_din_o(dm_din), .dm_we_o(dm_we), .dm_be_o(dm_be), .dm_dout_i(dm_dout)
  );

  dm_access_ctrl #(.BASE_ADDR(32'h0000_1000), .DM_BYTES(4096)) u_dut2 (
    .clk(clk), .rst(rst), .cpu_if(bus2),
    .dm_addr_o(dm2_addr), .dm_din_o(dm2_din), .dm_we_o(dm2_we), .dm_be_o(dm2_be), .dm_dout_i(dm2_dout)
  );

  // dm_4k stand-in: right-aligned din is steered into the lanes named by be
  function automatic logic [31:0] steer(input logic [31:0] old, input logic [31:0] din, input logic [3:0] be);
    logic [31:0] w;
    w = old;
    case (be)
      4'b1111: w = din;
      4'b0011: w[15:0]  = din[15:0];
      4'b1100: w[31:16] = din[15:0];
      4'b0001: w[7:0]   = din[7:0];
      4'b0010: w[15:8]  = din[7:0];
      4'b0100: w[23:16] = din[7:0];
      4'b1000: w[31:24] = din[7:0];
      default: w = old;
    endcase
    return w;
  endfunction

  logic [31:0] mem  [0:1023];
  logic [31:0] mem2 [0:1023];
  assign dm_dout  = mem[dm_addr];
  assign dm2_dout = mem2[dm2_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]  <= 32'd0;
        mem2[i] <= 32'd0;
      end
    end else begin
      if (dm_we)  mem[dm_addr]   <= steer(mem[dm_addr], dm_din, dm_be);
      if (dm2_we) mem2[dm2_addr] <= steer(mem2[dm2_addr], dm2_din, dm2_be);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: flat byte array for the BASE_ADDR=0 instance
  logic [7:0] mb [0:4095];

  task automatic model_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic fault, output logic [1:0] err, output logic [31:0] rdata,
                              output logic [31:0] bad, output logic [3:0] be, output logic [9:0] idx);
    int unsigned size;
    logic [63:0] v;
    bit st, sgn;
    st   = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    sgn  = (op == OP_LH) || (op == OP_LB);
    size = (op == OP_LW || op == OP_SW) ? 4 : ((op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1);
    fault = ((addr % size) != 0) || (addr >= 32'd4096);
    rdata = 32'd0;
    bad   = 32'd0;
    err   = 2'd0;
    be    = 4'(((1 << size) - 1) << addr[1:0]);
    idx   = addr[11:2];
    if (fault) begin
      err = st ? 2'd2 : 2'd1;
      bad = addr;
    end else if (st) begin
      for (int k = 0; k < int'(size); k++) mb[addr + k] = wdata[8*k +: 8];
    end else begin
      v = 64'd0;
      for (int k = 0; k < int'(size); k++) v = v + (64'(mb[addr + k]) << (8*k));
      if (sgn && v >= (64'd1 << (8*size - 1))) v = v - (64'd1 << (8*size));
      rdata = v[31:0];
    end
  endtask

  logic        chk_en = 1'b0;
  logic [1:0]  exp_err;
  logic [31:0] exp_rdata, exp_bad;
  int          we_cnt;
  logic [3:0]  we_be;
  logic [9:0]  we_addr;

  // Every cycle a response is up, it must equal the model's prediction
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (bus.resp_valid) begin
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_badaddr", bus.resp_badaddr, exp_bad);
        chk("req_ready_low_in_resp", 32'(bus.req_ready), 32'd0);
      end
      if (dm_we) begin
        we_cnt++;
        we_be   = dm_be;
        we_addr = dm_addr;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic [31:0] lit_rdata, input logic [1:0] lit_err,
                        input logic [31:0] lit_bad);
    logic       fault;
    logic [3:0] m_be;
    logic [9:0] m_idx;
    logic       st_ok;
    int         lat;
    wait_ready();
    model_access(op, addr, wdata, fault, exp_err, exp_rdata, exp_bad, m_be, m_idx);
    st_ok = (op >= OP_SW) && !fault;
    we_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    chk_en = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), fault ? 32'd1 : 32'd2);
    chk("lit_rdata", bus.resp_rdata, lit_rdata);
    chk("lit_err", 32'(bus.resp_err), 32'(lit_err));
    chk("lit_badaddr", bus.resp_badaddr, lit_bad);
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk_en = 1'b0;
    chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);
    chk("we_count", 32'(we_cnt), st_ok ? 32'd1 : 32'd0);
    if (st_ok) begin
      chk("we_be", 32'(we_be), 32'(m_be));
      chk("we_addr", 32'(we_addr), 32'(m_idx));
    end
  endtask

  task automatic do_req2(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [1:0] err, output logic [31:0] bad, output logic [31:0] rdata,
                         output int wes);
    int n;
    @(negedge clk);
    bus2.req_valid = 1'b1;
    bus2.req_op    = op;
    bus2.req_addr  = addr;
    bus2.req_wdata = wdata;
    wes = 0;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    n = 0;
    while (!bus2.resp_valid && n < 8) begin
      if (dm2_we) wes++;
      @(negedge clk);
      n++;
    end
    chk("dut2_resp_valid", 32'(bus2.resp_valid), 32'd1);
    err   = bus2.resp_err;
    bad   = bus2.resp_badaddr;
    rdata = bus2.resp_rdata;
    bus2.resp_ready = 1'b1;
    @(negedge clk);
    bus2.resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  e2;
    logic [31:0] b2, r2;
    int          w2;

    rst = 1'b1;
    mem_clr = 1'b1;
    bus.req_valid = 1'b0;  bus.req_op = 3'd0;  bus.req_addr = 32'd0;  bus.req_wdata = 32'd0;  bus.resp_ready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_op = 3'd0; bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0; bus2.resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mb[i] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_din", dm_din, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_badaddr", bus.resp_badaddr, 32'd0);
    rst = 1'b0;

    // word store and reload
    do_req(OP_SW, 32'h010, 32'h1234_5678, 0, 32'd0, 2'd0, 32'd0);
    chk("t1_be", 32'(we_be), 32'h0000_000F);
    chk("t1_addr", 32'(we_addr), 32'd4);
    do_req(OP_LW, 32'h010, 32'd0, 0, 32'h1234_5678, 2'd0, 32'd0);

    // byte store into top lane, signed and unsigned reload
    do_req(OP_SB, 32'h013, 32'h0000_00AB, 0, 32'd0, 2'd0, 32'd0);
    chk("t2_be", 32'(we_be), 32'h0000_0008);
    chk("t2_word", mem[4], 32'hAB34_5678);
    do_req(OP_LB,  32'h013, 32'd0, 0, 32'hFFFF_FFAB, 2'd0, 32'd0);
    do_req(OP_LBU, 32'h013, 32'd0, 0, 32'h0000_00AB, 2'd0, 32'd0);
    do_req(OP_LB,  32'h010, 32'd0, 0, 32'h0000_0078, 2'd0, 32'd0);
    do_req(OP_LB,  32'h011, 32'd0, 0, 32'h0000_0056, 2'd0, 32'd0);
    do_req(OP_LHU, 32'h012, 32'd0, 0, 32'h0000_AB34, 2'd0, 32'd0);
    do_req(OP_LH,  32'h012, 32'd0, 0, 32'hFFFF_AB34, 2'd0, 32'd0);

    // halfword store in upper half
    do_req(OP_SH, 32'h022, 32'h0000_8001, 0, 32'd0, 2'd0, 32'd0);
    chk("t3_be", 32'(we_be), 32'h0000_000C);
    do_req(OP_LH,  32'h022, 32'd0, 0, 32'hFFFF_8001, 2'd0, 32'd0);
    do_req(OP_LHU, 32'h020, 32'd0, 0, 32'h0000_0000, 2'd0, 32'd0);

    // alignment and window faults
    do_req(OP_LW, 32'h006, 32'd0, 0, 32'd0, 2'd1, 32'h0000_0006);
    do_req(OP_SH, 32'h001, 32'h0000_BEEF, 0, 32'd0, 2'd2, 32'h0000_0001);
    do_req(OP_SW, 32'h012, 32'h1111_1111, 0, 32'd0, 2'd2, 32'h0000_0012);
    do_req(OP_SB, 32'h1000, 32'h0000_0055, 0, 32'd0, 2'd2, 32'h0000_1000);
    do_req(OP_LW, 32'hFFFF_FFFC, 32'd0, 0, 32'd0, 2'd1, 32'hFFFF_FFFC);
    do_req(OP_LB, 32'h0FFF, 32'd0, 0, 32'd0, 2'd0, 32'd0);
    do_req(OP_SW, 32'h0FFC, 32'h55AA_33CC, 0, 32'd0, 2'd0, 32'd0);
    do_req(OP_LW, 32'h0FFC, 32'd0, 0, 32'h55AA_33CC, 2'd0, 32'd0);
    do_req(OP_LH, 32'h0FFE, 32'd0, 0, 32'h0000_55AA, 2'd0, 32'd0);
    do_req(OP_LB, 32'h0FFC, 32'd0, 0, 32'hFFFF_FFCC, 2'd0, 32'd0);

    // non-zero base window
    do_req2(OP_SW, 32'h2000, 32'h1234_5678, e2, b2, r2, w2);
    chk("b_sw_err", 32'(e2), 32'(ERR_ADES));
    chk("b_sw_bad", b2, 32'h0000_2000);
    chk("b_sw_we", 32'(w2), 32'd0);
    do_req2(OP_LW, 32'h0FFC, 32'd0, e2, b2, r2, w2);
    chk("b_lw_err", 32'(e2), 32'(ERR_ADEL));
    chk("b_lw_bad", b2, 32'h0000_0FFC);
    do_req2(OP_SW, 32'h1010, 32'hCAFE_F00D, e2, b2, r2, w2);
    chk("b_sw_ok_err", 32'(e2), 32'd0);
    chk("b_sw_ok_we", 32'(w2), 32'd1);
    chk("b_sw_ok_mem", mem2[4], 32'hCAFE_F00D);
    do_req2(OP_LW, 32'h1010, 32'd0, e2, b2, r2, w2);
    chk("b_lw_ok_rdata", r2, 32'hCAFE_F00D);
    do_req2(OP_LW, 32'h1FFC, 32'd0, e2, b2, r2, w2);
    chk("b_lw_top_err", 32'(e2), 32'd0);

    // stalled response stays stable
    do_req(OP_LW, 32'h010, 32'd0, 5, 32'hAB34_5678, 2'd0, 32'd0);

    // reset during the ACCESS cycle of a store
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SW;
    bus.req_addr  = 32'h040;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_pre_we", 32'(dm_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", 32'(dm_we), 32'd0);
    chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_kept", mem[16], 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
    do_req(OP_LW, 32'h040, 32'd0, 0, 32'd0, 2'd0, 32'd0);

    // reset discards a pending response
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LB;
    bus.req_addr  = 32'h2000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pend_valid", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("pend_discard", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(OP_LW, 32'h0FFC, 32'd0, 0, 32'h55AA_33CC, 2'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
